// File: rtl/vend_ctrl_multi_if.sv
// Bundle of front-end and dispenser/display signals around the vending controller.
// The front-end (coin/button side) is the master; the controller is the slave.
interface vend_ctrl_multi_if #(
  parameter int NUM_PROD = 4,
  parameter int VAL_W    = 8,
  parameter int SALES_W  = 16,
  parameter int CNT_W    = 8
);
  localparam int IDX_W = $clog2(NUM_PROD);

  logic                      enable;
  logic                      coin_valid;
  logic [VAL_W-1:0]          coin_value;
  logic                      coin_ack;
  logic                      sel_valid;
  logic [IDX_W-1:0]          sel_idx;
  logic [NUM_PROD*VAL_W-1:0] prices;
  logic                      cancel;
  logic                      sales_clr;
  logic [VAL_W-1:0]          credit;
  logic                      dispense_valid;
  logic [NUM_PROD-1:0]       dispense_sel;
  logic                      change_valid;
  logic [VAL_W-1:0]          change_amt;
  logic                      alarm;
  logic [SALES_W-1:0]        total_sales;
  logic [CNT_W-1:0]          sale_count;

  modport master (
    output enable, coin_valid, coin_value, sel_valid, sel_idx, prices, cancel, sales_clr,
    input  coin_ack, credit, dispense_valid, dispense_sel, change_valid, change_amt,
           alarm, total_sales, sale_count
  );

  modport slave (
    input  enable, coin_valid, coin_value, sel_valid, sel_idx, prices, cancel, sales_clr,
    output coin_ack, credit, dispense_valid, dispense_sel, change_valid, change_amt,
           alarm, total_sales, sale_count
  );
endinterface

// File: rtl/vend_ctrl_multi.sv
// Vending-machine controller: coin intake with credit saturation, per-slot
// prices, vend with change, cancel/timeout/close refund, alarm on bad selects,
// and saturating sales accounting. All outputs except coin_ack are registered,
// so dispense/change pulses appear the cycle after the deciding input.
module vend_ctrl_multi #(
  parameter int NUM_PROD    = 4,
  parameter int VAL_W       = 8,
  parameter int SALES_W     = 16,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 1024,
  parameter int ALARM_CYC   = 8
) (
  input logic              clk,
  input logic              rst_n,
  vend_ctrl_multi_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_PROD);
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam int ALM_W = $clog2(ALARM_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [ALM_W-1:0] ALM_LOAD = ALM_W'(ALARM_CYC);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_VEND,
    ST_REFUND
  } state_t;

  state_t               state_q, state_d;
  logic [VAL_W-1:0]     credit_q;
  logic [TMR_W-1:0]     timer_q;
  logic [ALM_W-1:0]     alarm_cnt_q;
  logic                 dispense_valid_q;
  logic [NUM_PROD-1:0]  dispense_sel_q;
  logic                 change_valid_q;
  logic [VAL_W-1:0]     change_amt_q;
  logic [SALES_W-1:0]   total_sales_q;
  logic [CNT_W-1:0]     sale_count_q;

  logic [VAL_W-1:0]     sel_price;
  logic [VAL_W:0]       credit_sum;
  logic                 coin_ok;
  logic                 timeout_hit;
  logic [NUM_PROD-1:0]  sel_onehot;
  logic [SALES_W:0]     sales_sum;
  logic [SALES_W-1:0]   sales_next;

  logic                 coin_take;
  logic                 do_vend;
  logic                 do_refund;
  logic                 do_alarm;
  logic                 timer_clr;

  // Price of the selected slot; an index past the last slot reads as 0 (disabled)
  always_comb begin
    sel_price = '0;
    for (int i = 0; i < NUM_PROD; i++) begin
      if (bus.sel_idx == IDX_W'(i)) begin
        sel_price = bus.prices[i*VAL_W +: VAL_W];
      end
    end
  end

  // Coin is acceptable only when it cannot overflow credit and no select/cancel competes
  assign credit_sum  = {1'b0, credit_q} + {1'b0, bus.coin_value};
  assign coin_ok     = bus.enable & bus.coin_valid & (bus.coin_value != '0) &
                       ~bus.sel_valid & ~bus.cancel & ~credit_sum[VAL_W];
  assign timeout_hit = (timer_q == TMR_LAST);
  assign sel_onehot  = {{(NUM_PROD-1){1'b0}}, 1'b1} << bus.sel_idx;
  assign sales_sum   = {1'b0, total_sales_q} + (SALES_W+1)'(sel_price);
  assign sales_next  = sales_sum[SALES_W] ? '1 : sales_sum[SALES_W-1:0];

  // Next-state and event decode; in CREDIT the order is close > cancel > select > timeout > coin
  always_comb begin
    state_d   = state_q;
    coin_take = 1'b0;
    do_vend   = 1'b0;
    do_refund = 1'b0;
    do_alarm  = 1'b0;
    timer_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (coin_ok) begin
          coin_take = 1'b1;
          state_d   = ST_CREDIT;
        end
      end
      ST_CREDIT: begin
        if (!bus.enable || bus.cancel) begin
          do_refund = 1'b1;
          state_d   = ST_REFUND;
        end else if (bus.sel_valid) begin
          timer_clr = 1'b1;
          if (sel_price == '0 || credit_q < sel_price) begin
            do_alarm = 1'b1;
          end else begin
            do_vend = 1'b1;
            state_d = ST_VEND;
          end
        end else if (timeout_hit) begin
          do_refund = 1'b1;
          state_d   = ST_REFUND;
        end else if (coin_ok) begin
          coin_take = 1'b1;
        end
      end
      ST_VEND:   state_d = ST_IDLE;
      ST_REFUND: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign bus.coin_ack = coin_take;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Credit, idle timer, output pulses, alarm countdown and sales totals
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q         <= '0;
      timer_q          <= '0;
      alarm_cnt_q      <= '0;
      dispense_valid_q <= 1'b0;
      dispense_sel_q   <= '0;
      change_valid_q   <= 1'b0;
      change_amt_q     <= '0;
      total_sales_q    <= '0;
      sale_count_q     <= '0;
    end else begin
      if (coin_take) begin
        credit_q <= credit_sum[VAL_W-1:0];
      end else if (do_vend || do_refund) begin
        credit_q <= '0;
      end

      if (state_d != ST_CREDIT || coin_take || timer_clr) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + 1'b1;
      end

      if (do_vend || do_refund) begin
        alarm_cnt_q <= '0;
      end else if (do_alarm) begin
        alarm_cnt_q <= ALM_LOAD;
      end else if (alarm_cnt_q != '0) begin
        alarm_cnt_q <= alarm_cnt_q - 1'b1;
      end

      dispense_valid_q <= do_vend;
      dispense_sel_q   <= do_vend ? sel_onehot : '0;
      change_valid_q   <= do_vend | do_refund;
      if (do_vend) begin
        change_amt_q <= credit_q - sel_price;
      end else if (do_refund) begin
        change_amt_q <= credit_q;
      end else begin
        change_amt_q <= '0;
      end

      if (bus.sales_clr) begin
        total_sales_q <= do_vend ? SALES_W'(sel_price) : '0;
        sale_count_q  <= do_vend ? CNT_W'(1) : '0;
      end else if (do_vend) begin
        total_sales_q <= sales_next;
        sale_count_q  <= sale_count_q + 1'b1;
      end
    end
  end

  assign bus.credit         = credit_q;
  assign bus.dispense_valid = dispense_valid_q;
  assign bus.dispense_sel   = dispense_sel_q;
  assign bus.change_valid   = change_valid_q;
  assign bus.change_amt     = change_amt_q;
  assign bus.alarm          = (alarm_cnt_q != '0);
  assign bus.total_sales    = total_sales_q;
  assign bus.sale_count     = sale_count_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Testbench for vend_ctrl_multi: a vector table of per-cycle stimulus with
// hand-derived expected outputs, queued at drive time and compared once the
// registered outputs settle, plus hand-written multi-cycle sequences.
module tb_vend_ctrl_multi;

  logic clk;
  logic rst_n;

  vend_ctrl_multi_if #(.NUM_PROD(4), .VAL_W(8), .SALES_W(16), .CNT_W(8)) bus ();

  vend_ctrl_multi #(
    .NUM_PROD(4), .VAL_W(8), .SALES_W(16), .CNT_W(8),
    .TIMEOUT_CYC(1024), .ALARM_CYC(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    bit        en;
    bit        cv;
    bit [7:0]  cval;
    bit        sv;
    bit [1:0]  sidx;
    bit        can;
    bit        clr;
    bit        ack;
    bit [7:0]  credit;
    bit        dv;
    bit [3:0]  dsel;
    bit        chv;
    bit [7:0]  chamt;
    bit        alarm;
    bit [15:0] total;
    bit [7:0]  count;
  } vec_t;

  vec_t vectors[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the bench stalls
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t v(input bit en, input bit cv, input bit [7:0] cval,
                             input bit sv, input bit [1:0] sidx, input bit can,
                             input bit clr, input bit ack, input bit [7:0] credit,
                             input bit dv, input bit [3:0] dsel, input bit chv,
                             input bit [7:0] chamt, input bit alarm,
                             input bit [15:0] total, input bit [7:0] count);
    vec_t r;
    r.en = en; r.cv = cv; r.cval = cval; r.sv = sv; r.sidx = sidx; r.can = can;
    r.clr = clr; r.ack = ack; r.credit = credit; r.dv = dv; r.dsel = dsel;
    r.chv = chv; r.chamt = chamt; r.alarm = alarm; r.total = total; r.count = count;
    return r;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic driveInputs(input bit en, input bit cv, input bit [7:0] cval, input bit sv,
                             input bit [1:0] sidx, input bit can, input bit clr);
    bus.enable     = en;
    bus.coin_valid = cv;
    bus.coin_value = cval;
    bus.sel_valid  = sv;
    bus.sel_idx    = sidx;
    bus.cancel     = can;
    bus.sales_clr  = clr;
  endtask

  // Pops the oldest expectation and compares it with the settled registered outputs
  task automatic checkOutput(input string tag);
    vec_t e;
    if (exp_q.size() == 0) begin
      checkVal({tag, " scoreboard empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    checkVal({tag, " credit"},         bus.credit,         e.credit);
    checkVal({tag, " dispense_valid"}, bus.dispense_valid, e.dv);
    checkVal({tag, " dispense_sel"},   bus.dispense_sel,   e.dsel);
    checkVal({tag, " change_valid"},   bus.change_valid,   e.chv);
    checkVal({tag, " change_amt"},     bus.change_amt,     e.chamt);
    checkVal({tag, " alarm"},          bus.alarm,          e.alarm);
    checkVal({tag, " total_sales"},    bus.total_sales,    e.total);
    checkVal({tag, " sale_count"},     bus.sale_count,     e.count);
  endtask

  // Drives one cycle of a record at the falling edge, checks coin_ack, queues the rest
  task automatic applyStimulus(input vec_t r, input string tag);
    driveInputs(r.en, r.cv, r.cval, r.sv, r.sidx, r.can, r.clr);
    #1;
    checkVal({tag, " coin_ack"}, bus.coin_ack, r.ack);
    exp_q.push_back(r);
    @(posedge clk);
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic driveOnly(input bit en, input bit cv, input bit [7:0] cval, input bit sv,
                           input bit [1:0] sidx, input bit can, input bit clr);
    driveInputs(en, cv, cval, sv, sidx, can, clr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic vendMax();
    driveOnly(1, 1, 8'd255, 0, 0, 0, 0);
    driveOnly(1, 0, 0, 1, 2'd2, 0, 0);
    driveOnly(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int n;
    bit got;

    // Slot prices: slot0=1, slot1=5, slot2=2, slot3=10
    bus.prices = {8'd10, 8'd2, 8'd5, 8'd1};
    driveInputs(1, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;

    // Vend with change 12-5=7
    vectors.push_back(v(1,1,5,  0,0,0,0, 1,5,  0,4'b0000,0,0,  0,0,0));
    vectors.push_back(v(1,1,5,  0,0,0,0, 1,10, 0,4'b0000,0,0,  0,0,0));
    vectors.push_back(v(1,1,2,  0,0,0,0, 1,12, 0,4'b0000,0,0,  0,0,0));
    vectors.push_back(v(1,0,0,  1,1,0,0, 0,0,  1,4'b0010,1,7,  0,5,1));
    vectors.push_back(v(1,0,0,  0,0,0,0, 0,0,  0,4'b0000,0,0,  0,5,1));
    // Insufficient credit: alarm for 8 cycles, credit kept, later vend of slot 3
    vectors.push_back(v(1,1,2,  0,0,0,0, 1,2,  0,4'b0000,0,0,  0,5,1));
    vectors.push_back(v(1,0,0,  1,3,0,0, 0,2,  0,4'b0000,0,0,  1,5,1));
    for (int i = 0; i < 7; i++)
      vectors.push_back(v(1,0,0,0,0,0,0, 0,2, 0,4'b0000,0,0, 1,5,1));
    vectors.push_back(v(1,0,0,  0,0,0,0, 0,2,  0,4'b0000,0,0,  0,5,1));
    vectors.push_back(v(1,1,5,  0,0,0,0, 1,7,  0,4'b0000,0,0,  0,5,1));
    vectors.push_back(v(1,1,5,  0,0,0,0, 1,12, 0,4'b0000,0,0,  0,5,1));
    vectors.push_back(v(1,0,0,  1,3,0,0, 0,0,  1,4'b1000,1,2,  0,15,2));
    vectors.push_back(v(1,0,0,  0,0,0,0, 0,0,  0,4'b0000,0,0,  0,15,2));
    // Alarm re-trigger, then cancel clears alarm and refunds
    vectors.push_back(v(1,1,1,  0,0,0,0, 1,1,  0,4'b0000,0,0,  0,15,2));
    vectors.push_back(v(1,0,0,  1,3,0,0, 0,1,  0,4'b0000,0,0,  1,15,2));
    vectors.push_back(v(1,0,0,  0,0,0,0, 0,1,  0,4'b0000,0,0,  1,15,2));
    vectors.push_back(v(1,0,0,  1,3,0,0, 0,1,  0,4'b0000,0,0,  1,15,2));
    vectors.push_back(v(1,0,0,  0,0,1,0, 0,0,  0,4'b0000,1,1,  0,15,2));
    vectors.push_back(v(1,0,0,  0,0,0,0, 0,0,  0,4'b0000,0,0,  0,15,2));
    // Credit saturation and coin+select in the same cycle
    vectors.push_back(v(1,1,250,0,0,0,0, 1,250,0,4'b0000,0,0,  0,15,2));
    vectors.push_back(v(1,1,10, 0,0,0,0, 0,250,0,4'b0000,0,0,  0,15,2));
    vectors.push_back(v(1,1,5,  1,1,0,0, 0,0,  1,4'b0010,1,245,0,20,3));
    vectors.push_back(v(1,0,0,  0,0,0,0, 0,0,  0,4'b0000,0,0,  0,20,3));
    vectors.push_back(v(1,1,255,0,0,0,0, 1,255,0,4'b0000,0,0,  0,20,3));
    vectors.push_back(v(1,1,1,  0,0,0,0, 0,255,0,4'b0000,0,0,  0,20,3));
    vectors.push_back(v(1,0,0,  0,0,1,0, 0,0,  0,4'b0000,1,255,0,20,3));
    vectors.push_back(v(1,0,0,  0,0,0,0, 0,0,  0,4'b0000,0,0,  0,20,3));
    // Zero-value coin, cancel in IDLE, closed machine, enable drop refund, select in IDLE
    vectors.push_back(v(1,1,0,  0,0,0,0, 0,0,  0,4'b0000,0,0,  0,20,3));
    vectors.push_back(v(1,0,0,  0,0,1,0, 0,0,  0,4'b0000,0,0,  0,20,3));
    vectors.push_back(v(0,1,5,  0,0,0,0, 0,0,  0,4'b0000,0,0,  0,20,3));
    vectors.push_back(v(1,1,3,  0,0,0,0, 1,3,  0,4'b0000,0,0,  0,20,3));
    vectors.push_back(v(0,0,0,  0,0,0,0, 0,0,  0,4'b0000,1,3,  0,20,3));
    vectors.push_back(v(1,0,0,  0,0,0,0, 0,0,  0,4'b0000,0,0,  0,20,3));
    vectors.push_back(v(1,0,0,  1,1,0,0, 0,0,  0,4'b0000,0,0,  0,20,3));

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkVal("reset credit",         bus.credit,         0);
    checkVal("reset dispense_valid", bus.dispense_valid, 0);
    checkVal("reset dispense_sel",   bus.dispense_sel,   0);
    checkVal("reset change_valid",   bus.change_valid,   0);
    checkVal("reset alarm",          bus.alarm,          0);
    checkVal("reset total_sales",    bus.total_sales,    0);
    rst_n = 1'b1;

    // Reset in the middle of a transaction discards credit without a change pulse
    applyStimulus(v(1,1,7, 0,0,0,0, 1,7, 0,4'b0000,0,0, 0,0,0), "midrst coin");
    rst_n = 1'b0;
    #1;
    checkVal("midrst credit",       bus.credit,       0);
    checkVal("midrst change_valid", bus.change_valid, 0);
    checkVal("midrst change_amt",   bus.change_amt,   0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(v(1,0,0, 0,0,0,0, 0,0, 0,4'b0000,0,0, 0,0,0), "midrst after");

    for (int i = 0; i < vectors.size(); i++) begin
      applyStimulus(vectors[i], $sformatf("vec%0d", i));
    end

    // Idle timeout refund after exactly 1024 cycles in CREDIT
    applyStimulus(v(1,1,6, 0,0,0,0, 1,6, 0,4'b0000,0,0, 0,20,3), "tmo coin");
    n = 0;
    got = 1'b0;
    for (int k = 1; k <= 2000 && !got; k++) begin
      driveOnly(1, 0, 0, 0, 0, 0, 0);
      if (bus.change_valid) begin
        got = 1'b1;
        n = k;
      end
    end
    checkVal("timeout latency",    n,              1024);
    checkVal("timeout change_amt", bus.change_amt, 6);
    checkVal("timeout credit",     bus.credit,     0);
    applyStimulus(v(1,0,0, 0,0,0,0, 0,0, 0,4'b0000,0,0, 0,20,3), "tmo after");

    // Accounting: clear, then drive total_sales to and past saturation with 255 vends
    applyStimulus(v(1,0,0, 0,0,0,1, 0,0, 0,4'b0000,0,0, 0,0,0), "clr");
    bus.prices = {8'd10, 8'd255, 8'd5, 8'd1};
    for (int k = 0; k < 256; k++) vendMax();
    checkVal("acc256 total_sales", bus.total_sales, 65280);
    checkVal("acc256 sale_count",  bus.sale_count,  0);
    vendMax();
    checkVal("acc257 total_sales", bus.total_sales, 65535);
    checkVal("acc257 sale_count",  bus.sale_count,  1);
    vendMax();
    checkVal("acc258 total_sales", bus.total_sales, 65535);
    checkVal("acc258 sale_count",  bus.sale_count,  2);

    // sales_clr coincident with a vend of price 5 (exact change)
    applyStimulus(v(1,1,5, 0,0,0,0, 1,5, 0,4'b0000,0,0, 0,65535,2), "clrvend coin");
    applyStimulus(v(1,0,0, 1,1,0,1, 0,0, 1,4'b0010,1,0, 0,5,1),     "clrvend sel");
    applyStimulus(v(1,0,0, 0,0,0,0, 0,0, 0,4'b0000,0,0, 0,5,1),     "clrvend after");

    // Disabled slot raises alarm and keeps credit
    bus.prices = {8'd10, 8'd0, 8'd5, 8'd1};
    applyStimulus(v(1,1,1, 0,0,0,0, 1,1, 0,4'b0000,0,0, 0,5,1), "dis coin");
    applyStimulus(v(1,0,0, 1,2,0,0, 0,1, 0,4'b0000,0,0, 1,5,1), "dis sel");
    applyStimulus(v(1,0,0, 0,0,1,0, 0,0, 0,4'b0000,1,1, 0,5,1), "dis cancel");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
